fifo_sync_param: RTL and testbench

Parametrised single-clock FIFO, the next generation of the team's fixed-size `fifo` block. It adds configurable data width and depth, an occupancy count, programmable almost-full and almost-empty thresholds, and overflow/underflow error pulses. An optional first-word-fall-through read mode is selected at compile time. It drops into the same slot as `fifo`, between a producer and a consumer in one clock domain, and its bench extends the existing FIFO interface/program environment.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_sync_param_if.sv | 34 +++
 rtl/fifo_mem.sv | 28 ++
 rtl/fifo_sync_param.sv | 103 ++++++++++
 tb/tb_fifo_sync_param.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO: default sizes,
// pointer-width helper and the error code enum used by bench scoreboards.
package fifo_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 16;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_OVF  = 2'd1,
    ERR_UDF  = 2'd2
  } fifo_err_e;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Producer/consumer handshake bundle for fifo_sync_param; the FIFO itself
// attaches through the slave modport, the surrounding logic through master.
interface fifo_sync_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              wr_en;
  logic [DATA_W-1:0] data_in;
  logic              rd_en;
  logic [DATA_W-1:0] data_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, data_in, rd_en,
    input  data_out, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en,
    output data_out, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  localparam int PTR_W = ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags and
// overflow/underflow pulses. Define FIFO_FWFT_EN for first-word-fall-through reads.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic clk,
  input  logic rst,
  fifo_sync_param_if.slave bus
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_LEVEL = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_LEVEL = CNT_W'(AE_THRESH);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              overflow_q;
  logic              underflow_q;
  logic              full_w;
  logic              empty_w;
  logic              wr_accept;
  logic              rd_accept;
  logic [DATA_W-1:0] mem_rdata;

  // Flags come from the registered count, never from pointer comparison
  assign full_w  = (count_q == CNT_FULL);
  assign empty_w = (count_q == '0);

  // A full FIFO still takes a write when the same cycle pops the head
  assign wr_accept = bus.wr_en && (!full_w || bus.rd_en);
  assign rd_accept = bus.rd_en && !empty_w;

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr),
    .wr_data (bus.data_in),
    .rd_addr (rd_ptr),
    .rd_data (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_accept, rd_accept})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      overflow_q  <= bus.wr_en && !wr_accept;
      underflow_q <= bus.rd_en && !rd_accept;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is presented combinationally; rd_en only acknowledges it
  assign bus.data_out = empty_w ? '0 : mem_rdata;
`else
  logic [DATA_W-1:0] data_out_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out_q <= '0;
    end else if (rd_accept) begin
      data_out_q <= mem_rdata;
    end
  end

  assign bus.data_out = data_out_q;
`endif

  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_q >= AF_LEVEL);
  assign bus.almost_empty = (count_q <= AE_LEVEL);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed self-checking bench for fifo_sync_param (DEPTH 16, AF 14, AE 2);
// expectations follow FIFO_FWFT_EN when the design is built with it.
module tb_fifo_sync_param;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fifo_sync_param_if #(.DATA_W(8), .DEPTH(16)) bus_if ();

  fifo_sync_param #(
    .DATA_W    (8),
    .DEPTH     (16),
    .AF_THRESH (14),
    .AE_THRESH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    bus_if.wr_en   = 1'b1;
    bus_if.data_in = v;
    tick();
    bus_if.wr_en   = 1'b0;
  endtask

  // The word a read returns: head before the edge in FWFT, register after it otherwise
  task automatic pop(output logic [7:0] v);
`ifdef FIFO_FWFT_EN
    v = bus_if.data_out;
    bus_if.rd_en = 1'b1;
    tick();
`else
    bus_if.rd_en = 1'b1;
    tick();
    v = bus_if.data_out;
`endif
    bus_if.rd_en = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] v;
    checks++; if (bus_if.count !== 5'd0) begin errors++; $display("[TB] FAIL por_count got %0d want 0", bus_if.count); end
    checks++; if (bus_if.empty !== 1'b1 || bus_if.almost_empty !== 1'b1) begin errors++; $display("[TB] FAIL por_empty got %b/%b want 1/1", bus_if.empty, bus_if.almost_empty); end
    checks++; if (bus_if.full !== 1'b0 || bus_if.almost_full !== 1'b0) begin errors++; $display("[TB] FAIL por_full got %b/%b want 0/0", bus_if.full, bus_if.almost_full); end
    checks++; if (bus_if.overflow !== 1'b0 || bus_if.underflow !== 1'b0 || bus_if.data_out !== 8'h00) begin errors++; $display("[TB] FAIL por_misc got ovf %b udf %b dout %h want 0 0 00", bus_if.overflow, bus_if.underflow, bus_if.data_out); end
    rst = 1'b1;
    tick();
    for (int i = 1; i <= 5; i++) push(8'(i));
    pop(v);
    checks++; if (v !== 8'h01) begin errors++; $display("[TB] FAIL pre_reset_read got %h want 01", v); end
    checks++; if (bus_if.count !== 5'd4) begin errors++; $display("[TB] FAIL pre_reset_count got %0d want 4", bus_if.count); end
    rst = 1'b0;
    #1;
    checks++; if (bus_if.count !== 5'd0 || bus_if.empty !== 1'b1 || bus_if.almost_empty !== 1'b1) begin errors++; $display("[TB] FAIL midreset_flags got cnt %0d e %b ae %b want 0 1 1", bus_if.count, bus_if.empty, bus_if.almost_empty); end
    checks++; if (bus_if.data_out !== 8'h00) begin errors++; $display("[TB] FAIL midreset_dout got %h want 00", bus_if.data_out); end
    tick();
    rst = 1'b1;
    tick();
    bus_if.rd_en = 1'b1;
    tick();
    bus_if.rd_en = 1'b0;
    checks++; if (bus_if.underflow !== 1'b1 || bus_if.data_out !== 8'h00 || bus_if.count !== 5'd0) begin errors++; $display("[TB] FAIL post_reset_read got udf %b dout %h cnt %0d want 1 00 0", bus_if.underflow, bus_if.data_out, bus_if.count); end
    tick();
    checks++; if (bus_if.underflow !== 1'b0) begin errors++; $display("[TB] FAIL udf_one_cycle got %b want 0", bus_if.underflow); end
  endtask

  task automatic test_fill_overflow;
    for (int i = 0; i < 16; i++) begin
      push(8'(i));
      checks++; if (bus_if.count !== 5'(i + 1)) begin errors++; $display("[TB] FAIL fill_count[%0d] got %0d want %0d", i, bus_if.count, i + 1); end
      checks++; if (bus_if.almost_full !== ((i + 1) >= 14)) begin errors++; $display("[TB] FAIL fill_af[%0d] got %b want %b", i, bus_if.almost_full, (i + 1) >= 14); end
      checks++; if (bus_if.full !== ((i + 1) == 16)) begin errors++; $display("[TB] FAIL fill_full[%0d] got %b want %b", i, bus_if.full, (i + 1) == 16); end
    end
    push(8'hAA);
    checks++; if (bus_if.overflow !== 1'b1 || bus_if.count !== 5'd16) begin errors++; $display("[TB] FAIL overflow got ovf %b cnt %0d want 1 16", bus_if.overflow, bus_if.count); end
    tick();
    checks++; if (bus_if.overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_one_cycle got %b want 0", bus_if.overflow); end
  endtask

  task automatic test_drain;
    logic [7:0] v;
    for (int i = 0; i < 16; i++) begin
      pop(v);
      checks++; if (v !== 8'(i)) begin errors++; $display("[TB] FAIL drain_data[%0d] got %h want %h", i, v, 8'(i)); end
      checks++; if (bus_if.count !== 5'(15 - i)) begin errors++; $display("[TB] FAIL drain_count[%0d] got %0d want %0d", i, bus_if.count, 15 - i); end
      checks++; if (bus_if.almost_empty !== ((15 - i) <= 2) || bus_if.empty !== (i == 15)) begin errors++; $display("[TB] FAIL drain_flags[%0d] got ae %b e %b want %b %b", i, bus_if.almost_empty, bus_if.empty, (15 - i) <= 2, i == 15); end
    end
    bus_if.rd_en = 1'b1;
    tick();
    bus_if.rd_en = 1'b0;
    checks++; if (bus_if.underflow !== 1'b1) begin errors++; $display("[TB] FAIL drain_underflow got %b want 1", bus_if.underflow); end
`ifdef FIFO_FWFT_EN
    checks++; if (bus_if.data_out !== 8'h00) begin errors++; $display("[TB] FAIL drain_hold got %h want 00", bus_if.data_out); end
`else
    checks++; if (bus_if.data_out !== 8'h0F) begin errors++; $display("[TB] FAIL drain_hold got %h want 0f", bus_if.data_out); end
`endif
    tick();
  endtask

  task automatic test_full_simul;
    logic [7:0] v;
    for (int i = 0; i < 16; i++) push(8'(i));
    bus_if.wr_en   = 1'b1;
    bus_if.data_in = 8'h55;
    pop(v);
    bus_if.wr_en   = 1'b0;
    checks++; if (v !== 8'h00) begin errors++; $display("[TB] FAIL simul_full_head got %h want 00", v); end
    checks++; if (bus_if.count !== 5'd16 || bus_if.overflow !== 1'b0) begin errors++; $display("[TB] FAIL simul_full_state got cnt %0d ovf %b want 16 0", bus_if.count, bus_if.overflow); end
    for (int i = 1; i <= 16; i++) begin
      pop(v);
      checks++; if (v !== ((i == 16) ? 8'h55 : 8'(i))) begin errors++; $display("[TB] FAIL simul_full_order[%0d] got %h want %h", i, v, (i == 16) ? 8'h55 : 8'(i)); end
    end
  endtask

  task automatic test_wrap;
    logic [7:0] v;
    for (int i = 0; i < 3; i++) push(8'(100 + i));
    for (int i = 0; i < 40; i++) begin
      bus_if.wr_en   = 1'b1;
      bus_if.data_in = 8'(103 + i);
      pop(v);
      bus_if.wr_en   = 1'b0;
      checks++; if (v !== 8'(100 + i) || bus_if.count !== 5'd3) begin errors++; $display("[TB] FAIL wrap[%0d] got %h cnt %0d want %h 3", i, v, bus_if.count, 8'(100 + i)); end
    end
    for (int i = 0; i < 3; i++) begin
      pop(v);
      checks++; if (v !== 8'(140 + i)) begin errors++; $display("[TB] FAIL wrap_tail[%0d] got %h want %h", i, v, 8'(140 + i)); end
    end
  endtask

  task automatic test_empty_simul;
    logic [7:0] v;
    bus_if.wr_en   = 1'b1;
    bus_if.rd_en   = 1'b1;
    bus_if.data_in = 8'h77;
    tick();
    bus_if.wr_en   = 1'b0;
    bus_if.rd_en   = 1'b0;
    checks++; if (bus_if.underflow !== 1'b1 || bus_if.count !== 5'd1 || bus_if.empty !== 1'b0) begin errors++; $display("[TB] FAIL simul_empty got udf %b cnt %0d e %b want 1 1 0", bus_if.underflow, bus_if.count, bus_if.empty); end
`ifdef FIFO_FWFT_EN
    checks++; if (bus_if.data_out !== 8'h77) begin errors++; $display("[TB] FAIL simul_empty_dout got %h want 77", bus_if.data_out); end
`else
    checks++; if (bus_if.data_out !== 8'h8E) begin errors++; $display("[TB] FAIL simul_empty_dout got %h want 8e", bus_if.data_out); end
`endif
    pop(v);
    checks++; if (v !== 8'h77 || bus_if.count !== 5'd0) begin errors++; $display("[TB] FAIL simul_empty_pop got %h cnt %0d want 77 0", v, bus_if.count); end
  endtask

  task automatic test_read_mode;
    push(8'h12);
`ifdef FIFO_FWFT_EN
    checks++; if (bus_if.data_out !== 8'h12) begin errors++; $display("[TB] FAIL fwft_present got %h want 12", bus_if.data_out); end
    bus_if.rd_en = 1'b1;
    tick();
    bus_if.rd_en = 1'b0;
    checks++; if (bus_if.empty !== 1'b1 || bus_if.data_out !== 8'h00) begin errors++; $display("[TB] FAIL fwft_pop got e %b dout %h want 1 00", bus_if.empty, bus_if.data_out); end
`else
    checks++; if (bus_if.data_out !== 8'h77) begin errors++; $display("[TB] FAIL no_bypass got %h want 77", bus_if.data_out); end
    bus_if.rd_en = 1'b1;
    tick();
    bus_if.rd_en = 1'b0;
    checks++; if (bus_if.empty !== 1'b1 || bus_if.data_out !== 8'h12) begin errors++; $display("[TB] FAIL std_read got e %b dout %h want 1 12", bus_if.empty, bus_if.data_out); end
`endif
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b0;
    bus_if.wr_en   = 1'b0;
    bus_if.rd_en   = 1'b0;
    bus_if.data_in = 8'h00;
    tick();
    tick();
    test_reset();
    test_fill_overflow();
    test_drain();
    test_full_simul();
    test_wrap();
    test_empty_simul();
    test_read_mode();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
